// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC sample reader.
//   XADC_CODE_W / PCM_W / XADC_WORD_W : widths of a raw code, a PCM sample and a wrapper word
//   cap_state_e                        : capture FSM states
//   code2pcm                           : 12-bit offset-binary code -> signed 16-bit PCM
package xadc_pkg;

  localparam int unsigned XADC_CODE_W = 12;
  localparam int unsigned PCM_W       = 16;
  localparam int unsigned XADC_WORD_W = 24;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWrA  = 2'd1,
    StWrB  = 2'd2
  } cap_state_e;

  // Flipping the MSB turns offset binary into two's complement; the shift scales to 16 bits.
  function automatic logic [PCM_W-1:0] code2pcm(input logic [XADC_CODE_W-1:0] code);
    return {~code[XADC_CODE_W-1], code[XADC_CODE_W-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/xadc_sample_reader_if.sv
// Sample stream towards the MFCC front end.
//   smp_data  : signed PCM sample (FIFO head)
//   smp_valid : smp_data is valid
//   smp_ready : consumer accepts the current sample
//   smp_first : current sample opens a frame
//   smp_last  : current sample closes a frame
// master = producer (sample reader), slave = consumer.
interface xadc_sample_reader_if;
  import xadc_pkg::*;

  logic [PCM_W-1:0] smp_data;
  logic             smp_valid;
  logic             smp_ready;
  logic             smp_first;
  logic             smp_last;

  modport master (
    output smp_data,
    output smp_valid,
    output smp_first,
    output smp_last,
    input  smp_ready
  );

  modport slave (
    input  smp_data,
    input  smp_valid,
    input  smp_first,
    input  smp_last,
    output smp_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a combinational (show-ahead) head.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : synchronous empty, takes priority over push/pop
//   push/wdata : write request and data
//   pop        : remove the head (ignored when empty)
//   rdata      : current head entry
//   empty/full : status from pointer comparison
//   fill       : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, fill_q;
  logic             do_push, do_pop;

  // Equal indices: the extra MSB tells a wrapped (full) writer from a caught-up (empty) one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign fill  = fill_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/xadc_sample_reader.sv
// Captures xadc_wrapper words, unpacks one or two 12-bit codes per word, converts them to
// signed PCM and streams them out of a FIFO with frame markers.
//   hclk, rst_n : clock, synchronous active-low reset
//   clear       : synchronous flush of FIFO, FSM, frame counter and overflow state
//   double      : packing mode of the incoming word, sampled on acceptance
//   din/din_vld : wrapper word and its one-cycle strobe
//   smp         : sample stream (master side)
//   overflow    : sticky, a word was dropped
//   drop_cnt    : dropped-word count, saturating
//   fill        : FIFO occupancy
module xadc_sample_reader import xadc_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FRAME_LEN  = 256
) (
  input  logic                          hclk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          double,
  input  logic [XADC_WORD_W-1:0]        din,
  input  logic                          din_vld,
  xadc_sample_reader_if.master          smp,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FRAME_LEN);

  cap_state_e             state_q;
  logic [XADC_WORD_W-1:0] hold_word_q;
  logic                   hold_dbl_q;
  logic [FW-1:0]          frame_cnt_q;

  logic                   fifo_empty, fifo_full;
  logic [PCM_W-1:0]       fifo_head;
  logic                   push, pop;
  logic [XADC_CODE_W-1:0] push_code;
  logic [AW+1:0]          free_cnt, need_cnt;
  logic                   space_ok, accept, drop;

  assign pop  = smp.smp_valid && smp.smp_ready;
  assign push = (state_q == StWrA) || (state_q == StWrB);

  // Sample A is the upper code of a double word; otherwise the lower code is used.
  assign push_code = ((state_q == StWrA) && hold_dbl_q) ? hold_word_q[23:12] : hold_word_q[11:0];

  // Free space counts a pop in this cycle; no push can be pending since acceptance needs StIdle.
  always_comb begin
    need_cnt = double ? (AW+2)'(2) : (AW+2)'(1);
    free_cnt = (AW+2)'(FIFO_DEPTH) - (AW+2)'(fill) + (AW+2)'(pop);
    if (fifo_full) space_ok = pop && !double;
    else           space_ok = (free_cnt >= need_cnt);
    accept = (state_q == StIdle) && din_vld && space_ok;
    drop   = din_vld && !accept;
  end

  always_ff @(posedge hclk) begin
    if (!rst_n || clear) begin
      state_q     <= StIdle;
      hold_word_q <= '0;
      hold_dbl_q  <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            hold_word_q <= din;
            hold_dbl_q  <= double;
            state_q     <= StWrA;
          end
        end
        StWrA:   state_q <= hold_dbl_q ? StWrB : StIdle;
        StWrB:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!rst_n || clear) begin
      frame_cnt_q <= '0;
    end else if (pop) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (hclk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (push),
    .wdata (code2pcm(push_code)),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .fill  (fill)
  );

  // Data is forced to zero while empty so the stream shows no stale memory contents.
  assign smp.smp_valid = !fifo_empty;
  assign smp.smp_data  = fifo_empty ? '0 : fifo_head;
  assign smp.smp_first = !fifo_empty && (frame_cnt_q == '0);
  assign smp.smp_last  = !fifo_empty && (frame_cnt_q == FW'(FRAME_LEN - 1));

endmodule

// File: tb/tb_xadc_sample_reader.sv
module tb_xadc_sample_reader;

  localparam int DEPTH = 4;
  localparam int FRAME = 4;

  logic        hclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        dbl = 1'b0;
  logic [23:0] din = '0;
  logic        din_vld = 1'b0;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [2:0]  fill;

  xadc_sample_reader_if smp_if ();

  xadc_sample_reader #(
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FRAME)
  ) dut (
    .hclk     (hclk),
    .rst_n    (rst_n),
    .clear    (clear),
    .double   (dbl),
    .din      (din),
    .din_vld  (din_vld),
    .smp      (smp_if),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .fill     (fill)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion straight from the arithmetic definition (code - 2048) * 16.
  function automatic logic [15:0] ref_pcm(input logic [11:0] code);
    int v;
    v = (int'(code) - 2048) * 16;
    return v[15:0];
  endfunction

  // ---------------- behavioural reference model ----------------
  // mq: samples currently in the FIFO; pend: accepted samples still to be written, one per cycle.
  logic [15:0] mq[$];
  logic [15:0] pend[$];
  int          fcnt = 0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  bit          model_ok = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } pop_t;
  pop_t plog[$];

  always @(negedge hclk) begin
    bit busy, mpop;
    int sz, need;
    if (model_ok) begin
      chk("valid", 32'(smp_if.smp_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("data", 32'(smp_if.smp_data), 32'(mq[0]));
      chk("first", 32'(smp_if.smp_first), 32'(mq.size() > 0 && fcnt == 0));
      chk("last", 32'(smp_if.smp_last), 32'(mq.size() > 0 && fcnt == FRAME - 1));
      chk("fill", 32'(fill), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (rst_n && !clear && smp_if.smp_valid && smp_if.smp_ready)
        plog.push_back('{smp_if.smp_data, smp_if.smp_first, smp_if.smp_last});
    end
    if (!rst_n || clear) begin
      mq.delete();
      pend.delete();
      fcnt = 0;
      m_ovf = 1'b0;
      m_drop = 0;
      if (!rst_n) model_ok = 1'b1;
    end else begin
      busy = (pend.size() > 0);
      sz   = mq.size();
      mpop = (sz > 0) && smp_if.smp_ready;
      if (mpop) begin
        void'(mq.pop_front());
        fcnt = (fcnt + 1) % FRAME;
      end
      if (busy) mq.push_back(pend.pop_front());
      if (din_vld) begin
        need = dbl ? 2 : 1;
        if (!busy && (DEPTH - sz + int'(mpop)) >= need) begin
          pend.push_back(ref_pcm(dbl ? din[23:12] : din[11:0]));
          if (dbl) pend.push_back(ref_pcm(din[11:0]));
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic d, input logic [23:0] w);
    tick();
    din = w;
    dbl = d;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic strobe_sp(input logic d, input logic [23:0] w);
    strobe(d, w);
    idle(1);
  endtask

  task automatic do_clear();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  typedef struct {
    logic [11:0] code;
    logic [15:0] pcm;
  } conv_vec_t;

  conv_vec_t   conv_tbl[6];
  logic [11:0] codes[9];

  initial begin
    conv_tbl[0] = '{12'h000, 16'h8000};
    conv_tbl[1] = '{12'h800, 16'h0000};
    conv_tbl[2] = '{12'hFFF, 16'h7FF0};
    conv_tbl[3] = '{12'h001, 16'h8010};
    conv_tbl[4] = '{12'h7FF, 16'hFFF0};
    conv_tbl[5] = '{12'hABC, 16'h2BC0};

    smp_if.smp_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    @(negedge hclk);
    chk("rst_valid", 32'(smp_if.smp_valid), 32'd0);
    chk("rst_data", 32'(smp_if.smp_data), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);

    // Conversion table, single mode; upper 12 bits carry junk that must be ignored.
    foreach (conv_tbl[i]) begin
      strobe(1'b0, {12'hA5A, conv_tbl[i].code});
      @(negedge hclk);
      @(negedge hclk);
      chk("conv_valid", 32'(smp_if.smp_valid), 32'd1);
      chk("conv_data", 32'(smp_if.smp_data), 32'(conv_tbl[i].pcm));
    end

    // Test 1: single word, latency and first marker.
    do_clear();
    strobe(1'b0, 24'h000FFF);
    @(negedge hclk);
    chk("t1_not_yet", 32'(smp_if.smp_valid), 32'd0);
    @(negedge hclk);
    chk("t1_valid", 32'(smp_if.smp_valid), 32'd1);
    chk("t1_data", 32'(smp_if.smp_data), 32'h7FF0);
    chk("t1_first", 32'(smp_if.smp_first), 32'd1);
    @(negedge hclk);
    chk("t1_fill", 32'(fill), 32'd0);

    // Test 2: double word, A then B; frame count goes 1 -> 3.
    strobe(1'b1, 24'h800000);
    @(negedge hclk);
    @(negedge hclk);
    chk("t2_a", 32'(smp_if.smp_data), 32'h0000);
    @(negedge hclk);
    chk("t2_b_valid", 32'(smp_if.smp_valid), 32'd1);
    chk("t2_b", 32'(smp_if.smp_data), 32'h8000);
    strobe(1'b0, 24'h000800);
    @(negedge hclk);
    @(negedge hclk);
    chk("t2_last", 32'(smp_if.smp_last), 32'd1);

    // Test 3: framing with random ready.
    do_clear();
    plog.delete();
    for (int i = 0; i < 9; i++) codes[i] = 12'(i * 451 + 85);
    begin
      int sent = 0;
      int gap = 3;
      for (int cyc = 0; cyc < 200 && sent < 9; cyc++) begin
        tick();
        din_vld = 1'b0;
        smp_if.smp_ready = ($urandom_range(0, 3) != 0);
        if (gap >= 3 && int'(fill) < DEPTH) begin
          din = {12'h3C3, codes[sent]};
          dbl = 1'b0;
          din_vld = 1'b1;
          sent++;
          gap = 0;
        end else begin
          gap++;
        end
      end
      tick();
      din_vld = 1'b0;
      chk("t3_sent_budget", 32'(sent), 32'd9);
    end
    smp_if.smp_ready = 1'b1;
    idle(10);
    chk("t3_count", 32'(plog.size()), 32'd9);
    foreach (plog[i]) begin
      if (i < 9) begin
        chk("t3_data", 32'(plog[i].data), 32'(ref_pcm(codes[i])));
        chk("t3_first", 32'(plog[i].first), 32'(i % 4 == 0));
        chk("t3_last", 32'(plog[i].last), 32'(i % 4 == 3));
      end
    end

    // Test 4: overflow with depth 4, ready low, three double words.
    do_clear();
    smp_if.smp_ready = 1'b0;
    plog.delete();
    strobe_sp(1'b1, 24'h123456);
    strobe_sp(1'b1, 24'hFEDCBA);
    strobe(1'b1, 24'h0F0F0F);
    @(negedge hclk);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    chk("t4_fill", 32'(fill), 32'd4);
    tick();
    smp_if.smp_ready = 1'b1;
    idle(6);
    chk("t4_count", 32'(plog.size()), 32'd4);
    if (plog.size() == 4) begin
      chk("t4_s0", 32'(plog[0].data), 32'(ref_pcm(12'h123)));
      chk("t4_s1", 32'(plog[1].data), 32'(ref_pcm(12'h456)));
      chk("t4_s2", 32'(plog[2].data), 32'(ref_pcm(12'hFED)));
      chk("t4_s3", 32'(plog[3].data), 32'(ref_pcm(12'hCBA)));
    end

    // Test 5: boundaries at full and a strobe during WR_B.
    do_clear();
    smp_if.smp_ready = 1'b0;
    strobe_sp(1'b0, 24'h000111);
    strobe_sp(1'b0, 24'h000222);
    strobe_sp(1'b0, 24'h000333);
    strobe_sp(1'b0, 24'h000444);
    @(negedge hclk);
    chk("t5_full_fill", 32'(fill), 32'd4);
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    tick();
    smp_if.smp_ready = 1'b1;
    tick();
    smp_if.smp_ready = 1'b0;
    strobe(1'b1, 24'h555666);
    @(negedge hclk);
    chk("t5_dbl_drop", 32'(drop_cnt), 32'd1);
    chk("t5_dbl_fill", 32'(fill), 32'd3);
    do_clear();
    smp_if.smp_ready = 1'b1;
    strobe(1'b1, 24'h777888);
    strobe(1'b0, 24'h000999);
    @(negedge hclk);
    chk("t5_wrb_drop", 32'(drop_cnt), 32'd1);
    chk("t5_wrb_ovf", 32'(overflow), 32'd1);
    idle(4);

    // Test 6: clear against strobe and pop, then reset during WR_A.
    smp_if.smp_ready = 1'b0;
    strobe_sp(1'b0, 24'h000ABC);
    strobe_sp(1'b0, 24'h000DEF);
    tick();
    clear = 1'b1;
    din = 24'h000123;
    dbl = 1'b0;
    din_vld = 1'b1;
    smp_if.smp_ready = 1'b1;
    tick();
    clear = 1'b0;
    din_vld = 1'b0;
    @(negedge hclk);
    chk("t6_fill", 32'(fill), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("t6_no_sample", 32'(smp_if.smp_valid), 32'd0);
    end
    smp_if.smp_ready = 1'b0;
    strobe(1'b1, 24'h111222);
    strobe(1'b0, 24'h000333);
    idle(3);
    strobe(1'b0, 24'h000444);
    rst_n = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    chk("t6_rst_valid", 32'(smp_if.smp_valid), 32'd0);
    chk("t6_rst_first", 32'(smp_if.smp_first), 32'd0);
    chk("t6_rst_last", 32'(smp_if.smp_last), 32'd0);
    chk("t6_rst_data", 32'(smp_if.smp_data), 32'd0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    chk("t6_rst_fill", 32'(fill), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic against the model: sparse then dense consumer.
    begin
      int gap = 3;
      for (int cyc = 0; cyc < 800; cyc++) begin
        tick();
        din_vld = 1'b0;
        clear = 1'b0;
        smp_if.smp_ready = (cyc < 400) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) clear = 1'b1;
        if ((gap >= 3 && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0) begin
          din = 24'($urandom);
          dbl = 1'($urandom_range(0, 1));
          din_vld = 1'b1;
          gap = 0;
        end else begin
          gap++;
        end
      end
    end
    tick();
    din_vld = 1'b0;
    clear = 1'b0;
    smp_if.smp_ready = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadc_sample_reader.md
# xadc_sample_reader

Consumer end of the XADC sample interface. It captures each `dout`/`drdy` word from `xadc_wrapper` and unpacks it into one or two samples, depending on `double`. Each 12-bit offset-binary code becomes a signed 16-bit PCM sample, and samples are buffered in a FIFO. The block presents them as a valid/ready stream with frame markers to the MFCC front end.

## Interface

Parameters:
- `FIFO_DEPTH`, 64: sample FIFO entries; power of 2, ≥4.
- `FRAME_LEN`, 256: samples per frame; power of 2, ≥2.

Ports:
- `hclk`  in  1: clock; single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `clear`  in  1: synchronous flush. Empties the FIFO, returns the FSM to IDLE, zeroes the frame counter, and clears `overflow` and `drop_cnt`.
- `double`  in  1: packing mode. Must match the `double` input of `xadc_wrapper`. Sampled when `din_vld` is accepted.
- `din`  in  24: sample word, from `xadc_wrapper.dout`.
- `din_vld`  in  1: one-cycle strobe, from `xadc_wrapper.drdy`.
- `smp_data`  out  16: signed PCM sample.
- `smp_valid`  out  1: `smp_data` is valid.
- `smp_ready`  in  1: downstream accept.
- `smp_first`  out  1: current sample is the first of a frame.
- `smp_last`  out  1: current sample is the last of a frame.
- `overflow`  out  1: sticky; a word was dropped.
- `drop_cnt`  out  8: dropped-word count; saturates at 255.
- `fill`  out  clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

**Word format** (fixed):
- `double`=0: sample = `din[11:0]`. `din[23:12]` is ignored.
- `double`=1: sample A = `din[23:12]` (older), sample B = `din[11:0]`. A is emitted before B.

**Conversion:** `pcm = {~code[11], code[10:0], 4'b0000}`, i.e. (code − 2048)·16.
- 0x000 → 0x8000
- 0x800 → 0x0000
- 0xFFF → 0x7FF0

**Capture FSM:** states IDLE, WR_A, WR_B.
- IDLE: on `din_vld`, the word is accepted only if free FIFO entries ≥ the needed count (2 if `double`, else 1).
  - Accepted: latch `din` and `double` into the holding register, then go to WR_A.
  - Not accepted: drop the whole word (never split), set `overflow`, and increment `drop_cnt` (saturating).
- WR_A: push sample A, or the single sample. Go to WR_B if the latched `double`=1, else to IDLE.
- WR_B: push sample B, then go to IDLE.
- `din_vld` arriving in WR_A or WR_B is dropped and counted as overflow. `xadc_wrapper` guarantees ≥3 cycles between strobes at legal `div`, so this is a fault indicator only.

**Free-space check:**
- Computed from the FIFO's `fill` in the cycle of `din_vld`.
- The check includes a pop occurring in the same cycle. It excludes pushes that are still pending.
- Because IDLE is required for acceptance, no pushes are pending at that point.

**Output stream:**
- `smp_valid` = FIFO not empty. `smp_data` is the FIFO head.
- The head pops on `smp_valid && smp_ready`.
- `smp_data` and `smp_valid` must hold while `smp_valid && !smp_ready`.

**Frame counter:**
- Counts popped samples, modulo `FRAME_LEN`.
- `smp_first` = (count == 0) && `smp_valid`.
- `smp_last` = (count == FRAME_LEN−1) && `smp_valid`.
- Wraps to 0 after the last sample of a frame is popped.

**`clear`:**
- Has priority over every other event in the same cycle, including `din_vld` and pop.
- Any word in the holding register is discarded.

## Timing

**Reset values (`rst_n`=0 at a clock edge):**
- `smp_valid`=0, `smp_first`=0, `smp_last`=0, `smp_data`=0
- `overflow`=0, `drop_cnt`=0, `fill`=0
- FSM = IDLE; frame count = 0
- Reset mid-burst discards all FIFO contents and any pending sample.

**Latency:**
- `din_vld` at cycle N → push at the end of N+1. `smp_valid`=1 in N+2.
- In double mode, sample B is pushed at the end of N+2.

**Simultaneous push and pop:** `fill` is unchanged. This is legal at full (pop frees the slot) and at empty-plus-push (the head appears next cycle, with no fall-through).

**FIFO:**
- Pointers are clog2(FIFO_DEPTH)+1 bits. Full/empty are decided by the pointer MSB.
- Pointers wrap naturally.

## Structure

**Package `xadc_pkg`:**
- `XADC_CODE_W`=12, `PCM_W`=16, `XADC_WORD_W`=24
- FSM state enum
- Conversion function `code2pcm`

**Sub-module `sync_fifo`:**
- Parameterised WIDTH and DEPTH.
- Synchronous active-low reset, plus a synchronous `flush` input.
- Outputs: registered `fill`, a combinational head, `empty`, and `full`.
- This is the only sub-module. The FSM, conversion, counters and framing live in `xadc_sample_reader`.

## Test plan

1. **Single mode, ready high.** `din`=0x000FFF, strobe at N.
   - `smp_valid` rises at N+2 with `smp_data`=0x7FF0 and `smp_first`=1.
   - `fill` returns to 0.
2. **Double mode.** `din`=0x800000.
   - Samples 0x0000 then 0x8000 on consecutive cycles.
   - The frame counter advances by 2.
3. **Framing.** FRAME_LEN=4, 9 single samples, `smp_ready` toggled randomly.
   - `smp_first` on samples 0, 4, 8.
   - `smp_last` on samples 3 and 7.
   - No sample is lost or reordered.
4. **Overflow.** FIFO_DEPTH=4, `smp_ready`=0, double mode, 3 words.
   - Words 1–2 fill the FIFO; word 3 is dropped.
   - `overflow`=1, `drop_cnt`=1, `fill`=4.
   - Then `smp_ready`=1 yields exactly 4 samples in order.
5. **Boundary at full.** FIFO one entry short of full, single-mode strobe.
   - Accepted: `fill`=DEPTH.
   - A double-mode strobe with one free entry is dropped whole.
   - Strobe while in WR_B → dropped and counted.
6. **Reset and clear.** Assert `clear` in the same cycle as `din_vld` and a pop: FIFO empty, counters 0, `overflow`=0, no sample emitted. Then assert `rst_n`=0 during WR_A: all outputs take their reset values the next cycle.
